axis_rr_arbiter: RTL and testbench
==================================

# axis_rr_arbiter

Packet-granular round-robin arbiter that multiplexes `NUM_INPUTS` AXI4-Stream sources carrying `axi_pkg::axi4s_payload_t` onto one AXI4-Stream sink. A grant is held for a whole packet, from its first beat until the beat with `TLAST` is accepted, so packets are never interleaved. Output is registered through a skid buffer so that `m_tready` has no combinational path to any `s_tready`. It sits between the per-source stream producers and the shared downstream consumer, such as a FIFO, a UART framer or a memory writer.

## Interface
- `NUM_INPUTS`, default 4: number of slave ports; legal range 2..16.
- `IDX_W`, default `$clog2(NUM_INPUTS)`: width of the grant index; derived, not overridden.
- `ACLK`  in  1  single clock; all logic is rising-edge.
- `ARESETN`  in  1  reset, synchronous and active-low.
- `s_tvalid`  in  NUM_INPUTS  per-source valid.
- `s_tready`  out  NUM_INPUTS  per-source ready.
- `s_tpayload`  in  NUM_INPUTS × axi4s_payload_t  per-source TDATA/TUSER/TLAST, as an unpacked array.
- `m_tvalid`  out  1  sink valid.
- `m_tready`  in  1  sink ready.
- `m_tpayload`  out  axi4s_payload_t  sink payload.
- `grant_idx`  out  IDX_W  index of the currently or last granted source.
- `busy`  out  1  high while a packet is locked (state BUSY).

## Operation
- FSM states:
  - IDLE: no source owns the path.
  - BUSY: the source `grant_idx` owns the path.
- IDLE → BUSY when any `s_tvalid` is high.
  - Winner is the first asserted `s_tvalid` scanning `(last+1) mod N, (last+2) mod N, …, last`, where `last` is the previously granted index.
  - `grant_idx` ← winner and `last` ← winner.
- BUSY:
  - `s_tready[grant_idx]` = skid-buffer input ready.
  - All other `s_tready` bits are 0.
  - Every input handshake pushes `s_tpayload[grant_idx]` into the skid buffer unchanged, including TUSER and TLAST.
- BUSY → IDLE on the cycle an input handshake occurs with `TLAST=1`.
  - The lock releases on input-side TLAST acceptance, not on output drain.
- In IDLE, all `s_tready` bits are 0.
- A single-beat packet (TLAST on its first beat) is legal and takes one BUSY cycle.
- A granted source that deasserts `s_tvalid` mid-packet keeps the grant indefinitely. There is no timeout.
- Skid buffer:
  - Two entries, main and spare.
  - Input ready = spare empty.
  - Output = main.
  - When `m_tready` is low while main is full, one additional beat is parked in spare.
  - Payload is never dropped or duplicated.
- `m_tpayload` holds its value while `m_tvalid && !m_tready`. This is the AXI stability rule.

## Timing
- Reset values (ARESETN=0 at a clock edge):
  - state = IDLE, `busy`=0, `s_tready`=0, `m_tvalid`=0, `m_tpayload`=0, `grant_idx`=0, skid entries empty.
  - `last` = NUM_INPUTS−1, so input 0 has first priority.
- Reset asserted mid-packet aborts the packet. Buffered beats are discarded and all outputs take their reset values on the next edge.
- Arbitration latency: a request seen in IDLE at cycle t gives `busy`=1 and `s_tready[winner]`=1 at t+1.
- Datapath latency: an input handshake at cycle t gives `m_tvalid`=1 with that beat at t+1.
- Back-to-back packets: one bubble cycle (IDLE) between the TLAST handshake and the next grant. Peak throughput is 1 beat/cycle within a packet.
- Input and output handshakes in the same cycle with spare empty do not stall. Full throughput is sustained when `m_tready`=1.
- A new request arriving in the same cycle as a TLAST handshake is not arbitrated until the IDLE cycle that follows.

## Structure
- Payload type, `AXI_DATA_WIDTH` and `AXI_USER_WIDTH` come from `axi_pkg`.
- A state enum `arb_state_e {ARB_IDLE, ARB_BUSY}` is added to `axi_pkg` for reuse by other stream controllers.
- One sub-module: `axis_skid_buffer`, a 2-entry register slice on `axi4s_payload_t` with valid/ready, synchronous active-low reset. It is reusable stand-alone.
- The round-robin scan is a function in the arbiter (rotate, priority-encode, unrotate). No separate module.

## Test plan
- Reset, then all `s_tvalid`=0 for 10 cycles → `m_tvalid`=0, `s_tready`=0, `busy`=0, `grant_idx`=0.
- Sources 0 and 2 each offer a 3-beat packet (TDATA 0x0A01..0x0A03 and 0x0C01..0x0C03), `m_tready`=1:
  - output is 0x0A01, 0x0A02, 0x0A03 (TLAST on the third beat), then 0x0C01..0x0C03;
  - there is exactly one idle output cycle between the two packets.
- All four sources continuously offer 1-beat packets (TDATA equal to the source index), `m_tready`=1 → grant order is 0,1,2,3,0,1,… and no source is starved.
- During a packet from source 1, `m_tready` toggles 1,0,0,1,0,1 → every beat 0x1101..0x1105 appears once, in order; `m_tpayload` is stable while stalled; TUSER is preserved.
- Source 3 drops `s_tvalid` for 5 cycles mid-packet while source 0 is requesting → grant stays at 3, and source 0 is served only after source 3's TLAST.
- ARESETN is pulsed low for 1 cycle after the second beat of a 4-beat packet → the next cycle shows reset values; after release, input 0 wins first.

Source files
------------

// File: rtl/axi_pkg.sv
// ---------------------------------------------------------------------------
// axi_pkg
// Shared AXI4-Stream definitions for the stream controllers.
//   AXI_DATA_WIDTH  : width of TDATA
//   AXI_USER_WIDTH  : width of TUSER
//   axi4s_payload_t : one stream beat (TDATA, TUSER, TLAST)
//   arb_state_e     : two-state lock FSM used by packet arbiters
// ---------------------------------------------------------------------------
package axi_pkg;

    localparam int AXI_DATA_WIDTH = 16;
    localparam int AXI_USER_WIDTH = 4;

    typedef struct packed {
        logic [AXI_DATA_WIDTH-1:0] tdata;
        logic [AXI_USER_WIDTH-1:0] tuser;
        logic                      tlast;
    } axi4s_payload_t;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_e;

endpackage

// File: rtl/axis_skid_buffer.sv
// ---------------------------------------------------------------------------
// axis_skid_buffer
// Two-entry register slice for axi4s_payload_t streams. The input ready is
// driven purely from a register, so the downstream ready never reaches the
// upstream ready combinationally.
//   clk_i        : clock, rising edge
//   rst_ni       : synchronous active-low reset
//   in_valid_i   : upstream valid
//   in_ready_o   : upstream ready (high while the spare entry is empty)
//   in_data_i    : upstream payload
//   out_valid_o  : downstream valid (main entry full)
//   out_ready_i  : downstream ready
//   out_data_o   : downstream payload (main entry)
// ---------------------------------------------------------------------------
module axis_skid_buffer
    import axi_pkg::*;
(
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic           in_valid_i,
    output logic           in_ready_o,
    input  axi4s_payload_t in_data_i,
    output logic           out_valid_o,
    input  logic           out_ready_i,
    output axi4s_payload_t out_data_o
);

    logic           mainValid_q, mainValid_d;
    logic           spareValid_q, spareValid_d;
    axi4s_payload_t mainData_q, mainData_d;
    axi4s_payload_t spareData_q, spareData_d;
    logic           push;
    logic           pop;

    assign in_ready_o  = !spareValid_q;
    assign out_valid_o = mainValid_q;
    assign out_data_o  = mainData_q;

    assign push = in_valid_i && !spareValid_q;
    assign pop  = mainValid_q && out_ready_i;

    // Main always holds the oldest beat. The spare only fills when a new beat
    // arrives while main is stalled, and it refills main on the next pop.
    // Main data is left untouched when main drains so the output stays quiet.
    always_comb begin
        mainValid_d  = mainValid_q;
        spareValid_d = spareValid_q;
        mainData_d   = mainData_q;
        spareData_d  = spareData_q;
        if (spareValid_q) begin
            if (pop) begin
                mainData_d   = spareData_q;
                spareValid_d = 1'b0;
            end
        end else if (!mainValid_q) begin
            if (push) begin
                mainValid_d = 1'b1;
                mainData_d  = in_data_i;
            end
        end else begin
            if (pop && push) begin
                mainData_d = in_data_i;
            end else if (pop) begin
                mainValid_d = 1'b0;
            end else if (push) begin
                spareValid_d = 1'b1;
                spareData_d  = in_data_i;
            end
        end
    end

    // Register update with synchronous reset that empties both entries.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            mainValid_q  <= 1'b0;
            spareValid_q <= 1'b0;
            mainData_q   <= '0;
            spareData_q  <= '0;
        end else begin
            mainValid_q  <= mainValid_d;
            spareValid_q <= spareValid_d;
            mainData_q   <= mainData_d;
            spareData_q  <= spareData_d;
        end
    end

endmodule

// File: rtl/axis_rr_arbiter.sv
// ---------------------------------------------------------------------------
// axis_rr_arbiter
// Packet-granular round-robin arbiter: NUM_INPUTS AXI4-Stream sources share
// one sink. A grant is locked from the first beat until the TLAST beat is
// accepted, and the output goes through a skid buffer.
//   ACLK        : clock, rising edge
//   ARESETN     : synchronous active-low reset
//   s_tvalid    : per-source valid
//   s_tready    : per-source ready (only the granted source, only in BUSY)
//   s_tpayload  : per-source payload, unpacked array
//   m_tvalid    : sink valid
//   m_tready    : sink ready
//   m_tpayload  : sink payload
//   grant_idx   : index of the current or most recent grant
//   busy        : a packet is locked
// ---------------------------------------------------------------------------
module axis_rr_arbiter
    import axi_pkg::*;
#(
    parameter int NUM_INPUTS = 4,
    parameter int IDX_W      = $clog2(NUM_INPUTS)
) (
    input  logic                  ACLK,
    input  logic                  ARESETN,
    input  logic [NUM_INPUTS-1:0] s_tvalid,
    output logic [NUM_INPUTS-1:0] s_tready,
    input  axi4s_payload_t        s_tpayload [NUM_INPUTS],
    output logic                  m_tvalid,
    input  logic                  m_tready,
    output axi4s_payload_t        m_tpayload,
    output logic [IDX_W-1:0]      grant_idx,
    output logic                  busy
);

    arb_state_e     state_q, state_d;
    logic [IDX_W-1:0] grant_q, grant_d;
    logic [IDX_W-1:0] last_q, last_d;
    logic           sbInValid;
    logic           sbInReady;
    axi4s_payload_t sbInData;
    logic           inHandshake;

    // Rotate the requests so the source after 'last' sits at bit 0, take the
    // lowest set bit, then map that position back to a source index.
    function automatic logic [IDX_W-1:0] rrPick(input logic [NUM_INPUTS-1:0] req,
                                               input logic [IDX_W-1:0]      last);
        logic [NUM_INPUTS-1:0] rot;
        logic [IDX_W-1:0]      idx;
        logic [IDX_W-1:0]      pick;
        int                    base;
        base = int'(last) + 1;
        for (int k = 0; k < NUM_INPUTS; k++) begin
            idx    = IDX_W'((base + k) % NUM_INPUTS);
            rot[k] = req[idx];
        end
        pick = last;
        for (int k = NUM_INPUTS - 1; k >= 0; k--) begin
            if (rot[k]) begin
                pick = IDX_W'((base + k) % NUM_INPUTS);
            end
        end
        return pick;
    endfunction

    assign busy      = (state_q == ARB_BUSY);
    assign grant_idx = grant_q;

    // Only the locked source can push into the skid buffer.
    assign sbInValid   = busy && s_tvalid[grant_q];
    assign sbInData    = s_tpayload[grant_q];
    assign inHandshake = sbInValid && sbInReady;

    // Ready fans out from the registered skid-buffer ready, never from m_tready.
    always_comb begin
        s_tready = '0;
        if (state_q == ARB_BUSY) begin
            s_tready[grant_q] = sbInReady;
        end
    end

    // Lock FSM: arbitrate only in IDLE, release as soon as the TLAST beat is
    // accepted on the input side so the next arbitration overlaps the drain.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        case (state_q)
            ARB_IDLE: begin
                if (|s_tvalid) begin
                    state_d = ARB_BUSY;
                    grant_d = rrPick(s_tvalid, last_q);
                    last_d  = rrPick(s_tvalid, last_q);
                end
            end
            ARB_BUSY: begin
                if (inHandshake && sbInData.tlast) begin
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // State registers; 'last' resets to the top index so source 0 wins first.
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            state_q <= ARB_IDLE;
            grant_q <= '0;
            last_q  <= IDX_W'(NUM_INPUTS - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end

    axis_skid_buffer u_skid (
        .clk_i       (ACLK),
        .rst_ni      (ARESETN),
        .in_valid_i  (sbInValid),
        .in_ready_o  (sbInReady),
        .in_data_i   (sbInData),
        .out_valid_o (m_tvalid),
        .out_ready_i (m_tready),
        .out_data_o  (m_tpayload)
    );

endmodule

// File: tb/tb_axis_rr_arbiter.sv
module tb_axis_rr_arbiter;
    import axi_pkg::*;

    localparam int N  = 4;
    localparam int IW = 2;
    localparam int QD = 16;

    logic           ACLK = 1'b0;
    logic           ARESETN;
    logic [N-1:0]   s_tvalid;
    logic [N-1:0]   s_tready;
    axi4s_payload_t s_tpayload [N];
    logic           m_tvalid;
    logic           m_tready;
    axi4s_payload_t m_tpayload;
    logic [IW-1:0]  grant_idx;
    logic           busy;

    always #5 ACLK = ~ACLK;

    axis_rr_arbiter #(.NUM_INPUTS(N)) dut (
        .ACLK       (ACLK),
        .ARESETN    (ARESETN),
        .s_tvalid   (s_tvalid),
        .s_tready   (s_tready),
        .s_tpayload (s_tpayload),
        .m_tvalid   (m_tvalid),
        .m_tready   (m_tready),
        .m_tpayload (m_tpayload),
        .grant_idx  (grant_idx),
        .busy       (busy)
    );

    int checks = 0;
    int errors = 0;

    // Source models: per-source beat list, presented in order while enabled.
    axi4s_payload_t srcMem [N][QD];
    int             srcWr [N];
    int             srcRd [N];
    logic [N-1:0]   srcEn;

    // Sink log of every accepted output beat.
    axi4s_payload_t outLog [64];
    int             outCnt;

    logic           prevStall;
    axi4s_payload_t prevPay;

    typedef struct {
        logic          mReady;
        logic [N-1:0]  en;
        logic          expValid;
        logic [15:0]   expData;
        logic          expLast;
        logic          expBusy;
        logic [IW-1:0] expGrant;
        logic [N-1:0]  expReady;
    } vec_t;

    vec_t vecs [9];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic driveSources();
        for (int i = 0; i < N; i++) begin
            if (srcEn[i] && (srcRd[i] < srcWr[i])) begin
                s_tvalid[i]   = 1'b1;
                s_tpayload[i] = srcMem[i][srcRd[i]];
            end else begin
                s_tvalid[i]   = 1'b0;
                s_tpayload[i] = '0;
            end
        end
    endtask

    task automatic pushBeat(input int src, input logic [15:0] d, input logic [3:0] u, input logic l);
        srcMem[src][srcWr[src]] = '{tdata: d, tuser: u, tlast: l};
        srcWr[src]++;
    endtask

    task automatic flushModels();
        for (int i = 0; i < N; i++) begin
            srcWr[i] = 0;
            srcRd[i] = 0;
        end
        srcEn     = '0;
        outCnt    = 0;
        prevStall = 1'b0;
        prevPay   = '0;
        driveSources();
    endtask

    task automatic applyStimulus(input vec_t v);
        m_tready = v.mReady;
        srcEn    = v.en;
        driveSources();
    endtask

    // One clock: observe handshakes at the falling edge, advance past the
    // rising edge, then update the source and sink models.
    task automatic step();
        logic [N-1:0]   hs;
        logic           mhs;
        logic           stall;
        axi4s_payload_t mp;
        @(negedge ACLK);
        hs    = s_tvalid & s_tready;
        mhs   = m_tvalid & m_tready;
        mp    = m_tpayload;
        stall = m_tvalid && !m_tready;
        if (prevStall) checkOutput("stable_payload", {11'd0, mp}, {11'd0, prevPay});
        prevStall = stall;
        prevPay   = mp;
        @(posedge ACLK);
        #1;
        if (ARESETN) begin
            for (int i = 0; i < N; i++) begin
                if (hs[i]) srcRd[i]++;
            end
            if (mhs && outCnt < 64) begin
                outLog[outCnt] = mp;
                outCnt++;
            end
        end
        driveSources();
    endtask

    task automatic doReset();
        ARESETN  = 1'b0;
        m_tready = 1'b0;
        flushModels();
        @(posedge ACLK);
        #1;
        @(posedge ACLK);
        #1;
        ARESETN = 1'b1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int budget;
        ARESETN  = 1'b0;
        m_tready = 1'b0;
        s_tvalid = '0;
        for (int i = 0; i < N; i++) s_tpayload[i] = '0;

        // Two-packet sequence, one row per cycle (expected after the edge).
        vecs[0] = '{1'b1, 4'b0101, 1'b0, 16'h0000, 1'b0, 1'b1, 2'd0, 4'b0001};
        vecs[1] = '{1'b1, 4'b0101, 1'b1, 16'h0A01, 1'b0, 1'b1, 2'd0, 4'b0001};
        vecs[2] = '{1'b1, 4'b0101, 1'b1, 16'h0A02, 1'b0, 1'b1, 2'd0, 4'b0001};
        vecs[3] = '{1'b1, 4'b0101, 1'b1, 16'h0A03, 1'b1, 1'b0, 2'd0, 4'b0000};
        vecs[4] = '{1'b1, 4'b0101, 1'b0, 16'h0000, 1'b0, 1'b1, 2'd2, 4'b0100};
        vecs[5] = '{1'b1, 4'b0101, 1'b1, 16'h0C01, 1'b0, 1'b1, 2'd2, 4'b0100};
        vecs[6] = '{1'b1, 4'b0101, 1'b1, 16'h0C02, 1'b0, 1'b1, 2'd2, 4'b0100};
        vecs[7] = '{1'b1, 4'b0101, 1'b1, 16'h0C03, 1'b1, 1'b0, 2'd2, 4'b0000};
        vecs[8] = '{1'b1, 4'b0101, 1'b0, 16'h0000, 1'b0, 1'b0, 2'd2, 4'b0000};

        // Idle after reset.
        doReset();
        m_tready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            step();
            checkOutput($sformatf("idle%0d_m_tvalid", c), 32'(m_tvalid), 32'd0);
            checkOutput($sformatf("idle%0d_s_tready", c), 32'(s_tready), 32'd0);
            checkOutput($sformatf("idle%0d_busy", c), 32'(busy), 32'd0);
            checkOutput($sformatf("idle%0d_grant", c), 32'(grant_idx), 32'd0);
        end
        checkOutput("idle_m_tpayload", {11'd0, m_tpayload}, 32'd0);

        // Sources 0 and 2, 3-beat packets each.
        doReset();
        pushBeat(0, 16'h0A01, 4'h1, 1'b0);
        pushBeat(0, 16'h0A02, 4'h2, 1'b0);
        pushBeat(0, 16'h0A03, 4'h3, 1'b1);
        pushBeat(2, 16'h0C01, 4'h4, 1'b0);
        pushBeat(2, 16'h0C02, 4'h5, 1'b0);
        pushBeat(2, 16'h0C03, 4'h6, 1'b1);
        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i]);
            step();
            checkOutput($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].expBusy));
            checkOutput($sformatf("vec%0d_grant", i), 32'(grant_idx), 32'(vecs[i].expGrant));
            checkOutput($sformatf("vec%0d_s_tready", i), 32'(s_tready), 32'(vecs[i].expReady));
            checkOutput($sformatf("vec%0d_m_tvalid", i), 32'(m_tvalid), 32'(vecs[i].expValid));
            if (vecs[i].expValid) begin
                checkOutput($sformatf("vec%0d_tdata", i), 32'(m_tpayload.tdata), 32'(vecs[i].expData));
                checkOutput($sformatf("vec%0d_tlast", i), 32'(m_tpayload.tlast), 32'(vecs[i].expLast));
            end
        end
        checkOutput("two_pkt_count", 32'(outCnt), 32'd6);

        // All four sources offering single-beat packets.
        doReset();
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < N; i++) pushBeat(i, 16'(i), 4'h0, 1'b1);
        end
        m_tready = 1'b1;
        srcEn    = '1;
        driveSources();
        budget = 0;
        while (outCnt < 12 && budget < 200) begin
            step();
            budget++;
        end
        checkOutput("rr_beats_done", 32'(outCnt >= 12), 32'd1);
        for (int k = 0; k < 12; k++) begin
            checkOutput($sformatf("rr_order%0d", k), 32'(outLog[k].tdata), 32'(k % 4));
        end

        // Backpressure on a 5-beat packet from source 1.
        doReset();
        for (int k = 0; k < 5; k++) pushBeat(1, 16'h1101 + 16'(k), 4'(k + 1), (k == 4));
        srcEn = 4'b0010;
        driveSources();
        budget = 0;
        while (outCnt < 5 && budget < 60) begin
            case (budget)
                3, 4, 6: m_tready = 1'b0;
                default: m_tready = 1'b1;
            endcase
            step();
            budget++;
        end
        m_tready = 1'b1;
        for (int c = 0; c < 5; c++) step();
        checkOutput("bp_count", 32'(outCnt), 32'd5);
        for (int k = 0; k < 5; k++) begin
            checkOutput($sformatf("bp_tdata%0d", k), 32'(outLog[k].tdata), 32'h1101 + 32'(k));
            checkOutput($sformatf("bp_tuser%0d", k), 32'(outLog[k].tuser), 32'(k + 1));
            checkOutput($sformatf("bp_tlast%0d", k), 32'(outLog[k].tlast), 32'(k == 4));
        end

        // Source 3 pauses mid-packet while source 0 is waiting.
        doReset();
        m_tready = 1'b1;
        for (int k = 0; k < 4; k++) pushBeat(3, 16'h3301 + 16'(k), 4'h3, (k == 3));
        srcEn = 4'b1000;
        driveSources();
        step();
        checkOutput("hold_first_grant", 32'(grant_idx), 32'd3);
        pushBeat(0, 16'h0001, 4'h0, 1'b0);
        pushBeat(0, 16'h0002, 4'h0, 1'b1);
        srcEn = 4'b1001;
        driveSources();
        budget = 0;
        while (srcRd[3] < 2 && budget < 20) begin
            step();
            budget++;
        end
        checkOutput("hold_two_beats", 32'(srcRd[3]), 32'd2);
        srcEn = 4'b0001;
        driveSources();
        for (int c = 0; c < 5; c++) begin
            step();
            checkOutput($sformatf("hold%0d_grant", c), 32'(grant_idx), 32'd3);
            checkOutput($sformatf("hold%0d_busy", c), 32'(busy), 32'd1);
            checkOutput($sformatf("hold%0d_s_tready0", c), 32'(s_tready[0]), 32'd0);
        end
        srcEn = 4'b1001;
        driveSources();
        budget = 0;
        while (outCnt < 6 && budget < 50) begin
            step();
            budget++;
        end
        checkOutput("hold_count", 32'(outCnt), 32'd6);
        for (int k = 0; k < 4; k++) begin
            checkOutput($sformatf("hold_out%0d", k), 32'(outLog[k].tdata), 32'h3301 + 32'(k));
        end
        checkOutput("hold_out4", 32'(outLog[4].tdata), 32'h0001);
        checkOutput("hold_out5", 32'(outLog[5].tdata), 32'h0002);

        // Reset pulse after two beats of a 4-beat packet.
        doReset();
        m_tready = 1'b1;
        for (int k = 0; k < 4; k++) pushBeat(2, 16'h2201 + 16'(k), 4'h2, (k == 3));
        srcEn = 4'b0100;
        driveSources();
        budget = 0;
        while (srcRd[2] < 2 && budget < 20) begin
            step();
            budget++;
        end
        checkOutput("rst_two_beats", 32'(srcRd[2]), 32'd2);
        ARESETN = 1'b0;
        @(posedge ACLK);
        #1;
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_s_tready", 32'(s_tready), 32'd0);
        checkOutput("rst_m_tvalid", 32'(m_tvalid), 32'd0);
        checkOutput("rst_m_tpayload", {11'd0, m_tpayload}, 32'd0);
        checkOutput("rst_grant", 32'(grant_idx), 32'd0);
        ARESETN = 1'b1;
        flushModels();
        pushBeat(0, 16'h0005, 4'h0, 1'b1);
        pushBeat(2, 16'h2205, 4'h0, 1'b1);
        srcEn = 4'b0101;
        driveSources();
        step();
        checkOutput("post_rst_busy", 32'(busy), 32'd1);
        checkOutput("post_rst_grant", 32'(grant_idx), 32'd0);
        checkOutput("post_rst_s_tready", 32'(s_tready), 32'b0001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
